// File: rtl/pe_scan_n.sv
// rtl/pe_scan_n.sv - sequential N-bit priority scanner; optional pend_cnt output under `PE_SCAN_COUNT_EN
module pe_scan_n #(
    parameter int N          = 8,
    parameter bit HIGH_FIRST = 1'b1,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_vec,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [W-1:0] idx,
    output logic         idx_none,
    output logic         idx_last
`ifdef PE_SCAN_COUNT_EN
    ,
    output logic [W:0]   pend_cnt
`endif
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic         none_q, none_d;

    logic [W-1:0] pri_idx;
    logic [N-1:0] pri_mask;
    logic [N-1:0] rest;
    logic         last;

    // Pick the winning pending bit; the later loop hit overrides, so loop order sets priority
    always_comb begin
        pri_idx  = '0;
        pri_mask = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pend_q[i]) begin
                    pri_idx     = W'(i);
                    pri_mask    = '0;
                    pri_mask[i] = 1'b1;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend_q[i]) begin
                    pri_idx     = W'(i);
                    pri_mask    = '0;
                    pri_mask[i] = 1'b1;
                end
            end
        end
    end

    // A beat is the last one when nothing remains after removing the served bit
    always_comb begin
        rest = pend_q & ~pri_mask;
        last = (rest == '0);
    end

    // Next-state and handshake decode; outputs depend only on registered state
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        none_d    = none_q;
        req_ready = 1'b0;
        idx_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    pend_d  = req_vec;
                    none_d  = (req_vec == '0);
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                idx_valid = 1'b1;
                if (idx_ready) begin
                    if (last) begin
                        pend_d  = '0;
                        none_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        pend_d = rest;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pending-bit and zero-vector flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
        end
    end

    assign idx      = (state_q == S_SERVE) ? pri_idx : '0;
    assign idx_none = none_q;
    assign idx_last = (state_q == S_SERVE) && last;

`ifdef PE_SCAN_COUNT_EN
    logic [W:0] cnt;

    // Popcount of the pending bits: beats still owed for the current vector
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + (W + 1)'(pend_q[i]);
        end
    end

    assign pend_cnt = cnt;
`endif

endmodule
